// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative RV32M/RV64M multiply/divide unit.
package muldiv_pkg;

  localparam int MULDIV_XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  // funct3[2] separates the divide group from the multiply group.
  function automatic logic is_div(muldiv_op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Operand/result handshake bundle between the execute-stage ALU and the multiply/divide unit.
interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int XLEN = MULDIV_XLEN_DEFAULT
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] rd;
  logic            busy;

  modport master (
    output in_valid, funct3, rs1, rs2, flush, out_ready,
    input  in_ready, out_valid, rd, busy
  );

  modport slave (
    input  in_valid, funct3, rs1, rs2, flush, out_ready,
    output in_ready, out_valid, rd, busy
  );
endinterface

// File: rtl/muldiv_shift_core.sv
// Iterative datapath: radix-2 shift-add multiply or restoring divide on unsigned magnitudes,
// one step per cycle while the down-counter is non-zero.
module muldiv_shift_core #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            is_div,
  input  logic            abort,
  input  logic [XLEN-1:0] a_in,
  input  logic [XLEN-1:0] b_in,
  output logic            last,
  output logic [XLEN-1:0] hi_nx,
  output logic [XLEN-1:0] lo_nx
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  hi_q, hi_d;
  logic [XLEN-1:0]  lo_q, lo_d;
  logic [XLEN-1:0]  b_q, b_d;
  logic             div_q, div_d;
  logic [XLEN:0]    sum;
  logic [XLEN:0]    trial;

  // hi holds the upper product half / partial remainder; lo the multiplier / dividend-quotient.
  always_comb begin
    cnt_d = cnt_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    b_d   = b_q;
    div_d = div_q;
    sum   = {1'b0, hi_q} + {1'b0, b_q};
    trial = {hi_q, lo_q[XLEN-1]} - {1'b0, b_q};
    if (abort) begin
      cnt_d = '0;
    end else if (start) begin
      cnt_d = CNT_W'(XLEN);
      hi_d  = '0;
      lo_d  = a_in;
      b_d   = b_in;
      div_d = is_div;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (div_q) begin
        // A clear top bit of the trial difference means no borrow: the divisor fits.
        if (!trial[XLEN]) begin
          hi_d = trial[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b1};
        end else begin
          hi_d = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
          lo_d = {lo_q[XLEN-2:0], 1'b0};
        end
      end else if (lo_q[0]) begin
        {hi_d, lo_d} = {sum, lo_q[XLEN-1:1]};
      end else begin
        {hi_d, lo_d} = {1'b0, hi_q, lo_q[XLEN-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      b_q   <= b_d;
      div_q <= div_d;
    end
  end

  assign last  = (cnt_q == CNT_W'(1));
  assign hi_nx = hi_d;
  assign lo_nx = lo_d;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M/RV64M multiply/divide unit: FSM, sign handling, special cases, handshakes.
// Define MULDIV_FAST_MUL_EN to resolve multiplies with a single-cycle combinational product.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int  XLEN  = MULDIV_XLEN_DEFAULT,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input  logic    clk,
  input  logic    rst_n,
  muldiv_if.slave io
);

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e   state_q, state_d;
  muldiv_op_e      op_q, op_d, op_in;
  logic            neg_q, neg_d, neg_in;
  logic [XLEN-1:0] rd_q, rd_d;
  logic            s1, s2, a_neg, b_neg, div_zero, ovf, accept, core_start, core_last;
  logic [XLEN-1:0] mag_a, mag_b, hi_nx, lo_nx;

  function automatic logic [XLEN-1:0] mul_fix(muldiv_op_e op, logic [2*XLEN-1:0] p, logic neg);
    logic [2*XLEN-1:0] s;
    s = neg ? -p : p;
    return (op == OP_MUL) ? s[XLEN-1:0] : s[2*XLEN-1:XLEN];
  endfunction

  function automatic logic [XLEN-1:0] div_fix(muldiv_op_e op, logic [XLEN-1:0] q,
                                              logic [XLEN-1:0] r, logic neg);
    if (op[1]) return neg ? -r : r;
    return neg ? -q : q;
  endfunction

  always_comb begin
    op_in    = muldiv_op_e'(io.funct3);
    s1       = op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    s2       = op_in inside {OP_MULH, OP_DIV, OP_REM};
    a_neg    = s1 & io.rs1[XLEN-1];
    b_neg    = s2 & io.rs2[XLEN-1];
    mag_a    = a_neg ? -io.rs1 : io.rs1;
    mag_b    = b_neg ? -io.rs2 : io.rs2;
    // The remainder takes the dividend's sign; everything else takes the XOR of both.
    neg_in   = (op_in == OP_REM) ? a_neg : (a_neg ^ b_neg);
    div_zero = is_div(op_in) && (io.rs2 == '0);
    ovf      = (op_in inside {OP_DIV, OP_REM}) && (io.rs1 == MOST_NEG) && (io.rs2 == '1);
    accept   = (state_q == IDLE) && io.in_valid && !io.flush;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
`endif

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    neg_d      = neg_q;
    rd_d       = rd_q;
    core_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d  = op_in;
          neg_d = neg_in;
          if (div_zero) begin
            rd_d    = op_in[1] ? io.rs1 : '1;
            state_d = DONE;
          end else if (ovf) begin
            rd_d    = op_in[1] ? '0 : MOST_NEG;
            state_d = DONE;
`ifdef MULDIV_FAST_MUL_EN
          end else if (!is_div(op_in)) begin
            rd_d    = mul_fix(op_in, fast_prod, neg_in);
            state_d = DONE;
`endif
          end else begin
            core_start = 1'b1;
            state_d    = CALC;
          end
        end
      end
      CALC: begin
        if (io.flush) begin
          state_d = IDLE;
        end else if (core_last) begin
          rd_d    = is_div(op_q) ? div_fix(op_q, lo_nx, hi_nx, neg_q)
                                 : mul_fix(op_q, {hi_nx, lo_nx}, neg_q);
          state_d = DONE;
        end
      end
      DONE: begin
        if (io.flush || io.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_MUL;
      neg_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      rd_q    <= rd_d;
    end
  end

  muldiv_shift_core #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (core_start),
    .is_div (is_div(op_in)),
    .abort  (io.flush),
    .a_in   (mag_a),
    .b_in   (mag_b),
    .last   (core_last),
    .hi_nx  (hi_nx),
    .lo_nx  (lo_nx)
  );

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = (state_q == DONE);
  assign io.busy      = (state_q != IDLE);
  assign io.rd        = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: arithmetic, boundary cases, latency,
// backpressure, flush and asynchronous reset.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int XLEN    = 32;
  localparam int DIV_LAT = XLEN + 1;
  localparam int SPC_LAT = 1;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = XLEN + 1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  muldiv_if #(.XLEN(XLEN)) bus ();

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one op, wait (bounded) for out_valid, check latency, result and in_ready.
  task automatic start_wait(input muldiv_op_e op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp, input int lat_exp, input string tag);
    int lat;
    bit inr_low;
    bus.funct3   = op;
    bus.rs1      = a;
    bus.rs2      = b;
    bus.in_valid = 1'b1;
    chk({tag, "_in_ready_idle"}, 64'(bus.in_ready), 64'd1);
    step();
    bus.in_valid = 1'b0;
    lat     = 1;
    inr_low = 1'b1;
    while (!bus.out_valid && lat < 200) begin
      if (bus.in_ready) inr_low = 1'b0;
      step();
      lat++;
    end
    $display("op=%s rs1=0x%h rs2=0x%h rd=0x%h latency=%0d", op.name(), a, b, bus.rd, lat);
    chk({tag, "_latency"}, 64'(lat), 64'(lat_exp));
    chk({tag, "_rd"}, 64'(bus.rd), 64'(exp));
    chk({tag, "_in_ready_done"}, 64'(bus.in_ready), 64'd0);
    if (lat_exp > 1) chk({tag, "_in_ready_calc"}, 64'(inr_low), 64'd1);
  endtask

  task automatic run_op(input muldiv_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat_exp, input string tag);
    start_wait(op, a, b, exp, lat_exp, tag);
    step();
    chk({tag, "_out_valid_drop"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    bit seen;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    bus.funct3    = 3'd0;
    bus.rs1       = '0;
    bus.rs2       = '0;
    #12;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_rd", 64'(bus.rd), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    #10 rst_n = 1'b1;
    step();

    run_op(OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT, "mul");
    run_op(OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT, "mulh");
    run_op(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT, "mulhu");
    run_op(OP_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, MUL_LAT, "mulhsu");
    run_op(OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, DIV_LAT, "div_neg");
    run_op(OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, DIV_LAT, "rem_neg");
    run_op(OP_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, DIV_LAT, "div_negdiv");
    run_op(OP_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        DIV_LAT, "rem_negdiv");
    run_op(OP_DIVU,   32'd100,      32'd7,        32'd14,       DIV_LAT, "divu");
    run_op(OP_REMU,   32'd100,      32'd7,        32'd2,        DIV_LAT, "remu");
    run_op(OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, SPC_LAT, "divu_zero");
    run_op(OP_REMU,   32'd5,        32'd0,        32'd5,        SPC_LAT, "remu_zero");
    run_op(OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, SPC_LAT, "div_ovf");
    run_op(OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        SPC_LAT, "rem_ovf");

    // Backpressure: result must hold while out_ready is low.
    bus.out_ready = 1'b0;
    start_wait(OP_DIVU, 32'd100, 32'd9, 32'd11, DIV_LAT, "hold");
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_out_valid", 64'(bus.out_valid), 64'd1);
      chk("hold_rd", 64'(bus.rd), 64'd11);
      chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    step();
    chk("release_out_valid", 64'(bus.out_valid), 64'd0);
    chk("release_in_ready", 64'(bus.in_ready), 64'd1);
    run_op(OP_MULHU, 32'h00010000, 32'h00010000, 32'd1, MUL_LAT, "after_hold");

    // flush together with in_valid in IDLE: op must not be taken.
    bus.funct3   = OP_DIV;
    bus.rs1      = 32'd10;
    bus.rs2      = 32'd3;
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    chk("flush_idle_busy", 64'(bus.busy), 64'd0);
    $display("op=DIV flushed in IDLE busy=%0d", bus.busy);

    // flush at cycle 12 of a DIV.
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (11) step();
    chk("flush_calc_busy_before", 64'(bus.busy), 64'd1);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("flush_calc_busy", 64'(bus.busy), 64'd0);
    chk("flush_calc_in_ready", 64'(bus.in_ready), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid) seen = 1'b1;
      step();
    end
    chk("flush_no_result", 64'(seen), 64'd0);
    $display("op=DIV flushed in CALC out_valid_seen=%0d", seen);

    // Asynchronous reset in the middle of a MUL.
    bus.funct3   = OP_MUL;
    bus.rs1      = 32'd5;
    bus.rs2      = 32'd6;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (5) step();
    chk("arst_busy_before", 64'(bus.busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_rd", 64'(bus.rd), 64'd0);
    $display("async reset mid-MUL busy=%0d rd=0x%h", bus.busy, bus.rd);
    #10 rst_n = 1'b1;
    step();
    run_op(OP_MUL, 32'd3, 32'd4, 32'd12, MUL_LAT, "mul_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
